pipe_ctrl_regs: RTL and testbench

//  Stage-to-stage control pipeline (ID->EX->MEM->WB). It is the producer of the EX/MEM stage signals
//  (EXwreg, EXm2reg, EXwn, MEMwreg, MEMm2reg, MEMwn) that the ID-stage hazard/forwarding unit consumes.
//  It registers the decoded ID controls and inserts a bubble into EX on a load-use stall or branch flush.
//  It also carries destination register numbers to WB, where they drive the register-file write port.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_ctrl_regs_if.sv | 47 ++++
 rtl/pipe_ctrl_stage.sv | 26 ++
 rtl/pipe_ctrl_regs.sv | 82 ++++++++
 tb/tb_pipe_ctrl_regs.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stage-word packing helpers and the bubble constant for the
// ID->EX->MEM->WB control pipeline.
package pipe_ctrl_pkg;

  localparam int RW_D     = 5;
  localparam int ALUC_W_D = 4;

  // Stage words are packed MSB first:
  //   EX : valid, wreg, m2reg, wmem, sst, sext, shift, aluc, selA, selB, wn, stfwd
  //   MEM: valid, wreg, m2reg, wmem, wn, stfwd
  //   WB : valid, wreg, m2reg, wn
  function automatic int ex_word_w(input int rw, input int aluc_w);
    return 12 + aluc_w + rw;
  endfunction

  function automatic int mem_word_w(input int rw);
    return 5 + rw;
  endfunction

  function automatic int wb_word_w(input int rw);
    return 3 + rw;
  endfunction

  localparam int BUBBLE_MAX_W = 64;
  localparam logic [BUBBLE_MAX_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_regs_if.sv
// ID-stage control inputs and EX/MEM/WB stage outputs of the control pipeline.
// master = decoder/hazard side, slave = pipe_ctrl_regs.
interface pipe_ctrl_regs_if #(
  parameter int RW     = pipe_ctrl_pkg::RW_D,
  parameter int ALUC_W = pipe_ctrl_pkg::ALUC_W_D,
  parameter int CNT_W  = 32
);
  logic              IDwir, flush;
  logic              IDwreg, IDm2reg, IDwmem, IDsst, IDsext, IDshift;
  logic [ALUC_W-1:0] IDaluc;
  logic [1:0]        IDselectAlua, IDselectAlub;
  logic [RW-1:0]     IDwn;
  logic              is_store_hazards;

  logic              EXvalid, EXwreg, EXm2reg, EXwmem, EXsst, EXsext, EXshift;
  logic [ALUC_W-1:0] EXaluc;
  logic [1:0]        EXselectAlua, EXselectAlub;
  logic [RW-1:0]     EXwn;
  logic              EXstfwd;

  logic              MEMvalid, MEMwreg, MEMm2reg, MEMwmem;
  logic [RW-1:0]     MEMwn;
  logic              MEMstfwd;

  logic              WBvalid, WBwreg, WBm2reg;
  logic [RW-1:0]     WBwn;

  logic [CNT_W-1:0]  stall_cnt, flush_cnt, retire_cnt;

  modport master (
    output IDwir, flush, IDwreg, IDm2reg, IDwmem, IDsst, IDsext, IDshift, IDaluc,
           IDselectAlua, IDselectAlub, IDwn, is_store_hazards,
    input  EXvalid, EXwreg, EXm2reg, EXwmem, EXsst, EXsext, EXshift, EXaluc,
           EXselectAlua, EXselectAlub, EXwn, EXstfwd,
           MEMvalid, MEMwreg, MEMm2reg, MEMwmem, MEMwn, MEMstfwd,
           WBvalid, WBwreg, WBm2reg, WBwn, stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  IDwir, flush, IDwreg, IDm2reg, IDwmem, IDsst, IDsext, IDshift, IDaluc,
           IDselectAlua, IDselectAlub, IDwn, is_store_hazards,
    output EXvalid, EXwreg, EXm2reg, EXwmem, EXsst, EXsext, EXshift, EXaluc,
           EXselectAlua, EXselectAlub, EXwn, EXstfwd,
           MEMvalid, MEMwreg, MEMm2reg, MEMwmem, MEMwn, MEMstfwd,
           WBvalid, WBwreg, WBm2reg, WBwn, stall_cnt, flush_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_ctrl_stage.sv
// One pipeline register of W bits: async-low reset to zero, bubble loads the
// all-zero word, otherwise captures d.
module pipe_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_bubble,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // NOTE: non-blocking assignment so every stage samples its neighbour's old value on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_q <= '0;
    else if (i_bubble) r_q <= BUBBLE[W-1:0];
    else               r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl_regs.sv
// ID->EX->MEM->WB control pipeline with stall/flush bubble insertion and r0 gating.
// Optional saturating performance counters are built when PIPE_PERF_EN is defined.
module pipe_ctrl_regs
  import pipe_ctrl_pkg::*;
#(
  parameter int RW     = RW_D,
  parameter int ALUC_W = ALUC_W_D,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              resetn,
  pipe_ctrl_regs_if.slave   bus
);

  localparam int EXW  = ex_word_w(RW, ALUC_W);
  localparam int MEMW = mem_word_w(RW);
  localparam int WBW  = wb_word_w(RW);

  logic            w_ex_bubble;
  logic            w_id_wreg;
  logic [EXW-1:0]  w_ex_d,  w_ex_q;
  logic [MEMW-1:0] w_mem_d, w_mem_q;
  logic [WBW-1:0]  w_wb_d,  w_wb_q;

  assign w_ex_bubble = ~bus.IDwir | bus.flush;
  // Writes to r0 are dropped here so forwarding and WB never see them.
  assign w_id_wreg   = bus.IDwreg & (bus.IDwn != '0);

  assign w_ex_d = {1'b1, w_id_wreg, bus.IDm2reg, bus.IDwmem, bus.IDsst, bus.IDsext,
                   bus.IDshift, bus.IDaluc, bus.IDselectAlua, bus.IDselectAlub,
                   bus.IDwn, bus.is_store_hazards};

  pipe_ctrl_stage #(.W(EXW)) u_id_ex (
    .clk(clock), .rst_n(resetn), .i_bubble(w_ex_bubble), .i_d(w_ex_d), .o_q(w_ex_q)
  );

  assign {bus.EXvalid, bus.EXwreg, bus.EXm2reg, bus.EXwmem, bus.EXsst, bus.EXsext,
          bus.EXshift, bus.EXaluc, bus.EXselectAlua, bus.EXselectAlub,
          bus.EXwn, bus.EXstfwd} = w_ex_q;

  assign w_mem_d = {bus.EXvalid, bus.EXwreg, bus.EXm2reg, bus.EXwmem, bus.EXwn, bus.EXstfwd};

  pipe_ctrl_stage #(.W(MEMW)) u_ex_mem (
    .clk(clock), .rst_n(resetn), .i_bubble(1'b0), .i_d(w_mem_d), .o_q(w_mem_q)
  );

  assign {bus.MEMvalid, bus.MEMwreg, bus.MEMm2reg, bus.MEMwmem, bus.MEMwn, bus.MEMstfwd} = w_mem_q;

  assign w_wb_d = {bus.MEMvalid, bus.MEMwreg, bus.MEMm2reg, bus.MEMwn};

  pipe_ctrl_stage #(.W(WBW)) u_mem_wb (
    .clk(clock), .rst_n(resetn), .i_bubble(1'b0), .i_d(w_wb_d), .o_q(w_wb_q)
  );

  assign {bus.WBvalid, bus.WBwreg, bus.WBm2reg, bus.WBwn} = w_wb_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_retire_cnt;

  // A stall coinciding with a flush is attributed to the flush only.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (!bus.IDwir && !bus.flush && !(&r_stall_cnt)) r_stall_cnt  <= r_stall_cnt + CNT_W'(1);
      if (bus.flush && !(&r_flush_cnt))                 r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
      if (bus.WBvalid && !(&r_retire_cnt))              r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.flush_cnt  = r_flush_cnt;
  assign bus.retire_cnt = r_retire_cnt;
`else
  assign bus.stall_cnt  = {CNT_W{1'b0}};
  assign bus.flush_cnt  = {CNT_W{1'b0}};
  assign bus.retire_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Self-checking bench for pipe_ctrl_regs: directed scenarios then random traffic,
// compared against a history-queue model of what entered EX each cycle.
module tb_pipe_ctrl_regs;

  localparam int RW = 5;
  localparam int AW = 4;
`ifdef PIPE_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 32;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_regs_if #(.RW(RW), .ALUC_W(AW), .CNT_W(CW)) bus ();

  pipe_ctrl_regs #(.RW(RW), .ALUC_W(AW), .CNT_W(CW)) dut (
    .clock(clk), .resetn(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic          valid, wreg, m2reg, wmem, sst, sext, shift;
    logic [AW-1:0] aluc;
    logic [1:0]    sela, selb;
    logic [RW-1:0] wn;
    logic          stfwd;
  } ent_t;

  // hist[0] = EX, hist[1] = MEM, hist[2] = WB
  ent_t hist[$];
  int   exp_stall, exp_flush, exp_retire;
  int   n_checks, n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t op(input logic wreg, input logic m2reg, input logic wmem,
                              input logic [AW-1:0] aluc, input logic [RW-1:0] wn);
    ent_t e = '0;
    e.wreg = wreg; e.m2reg = m2reg; e.wmem = wmem; e.aluc = aluc; e.wn = wn;
    return e;
  endfunction

  task automatic set_id(input logic wir, input logic fl, input ent_t f);
    bus.IDwir = wir;            bus.flush = fl;
    bus.IDwreg = f.wreg;        bus.IDm2reg = f.m2reg;      bus.IDwmem = f.wmem;
    bus.IDsst = f.sst;          bus.IDsext = f.sext;        bus.IDshift = f.shift;
    bus.IDaluc = f.aluc;        bus.IDselectAlua = f.sela;  bus.IDselectAlub = f.selb;
    bus.IDwn = f.wn;            bus.is_store_hazards = f.stfwd;
  endtask

  function automatic ent_t id_entry();
    ent_t e = '0;
    if (bus.IDwir && !bus.flush) begin
      e.valid = 1'b1;
      e.wreg  = bus.IDwreg && (bus.IDwn != 0);
      e.m2reg = bus.IDm2reg; e.wmem = bus.IDwmem; e.sst = bus.IDsst;
      e.sext  = bus.IDsext;  e.shift = bus.IDshift; e.aluc = bus.IDaluc;
      e.sela  = bus.IDselectAlua; e.selb = bus.IDselectAlub;
      e.wn    = bus.IDwn;    e.stfwd = bus.is_store_hazards;
    end
    return e;
  endfunction

  function automatic logic [63:0] sat(input int c);
`ifdef PIPE_PERF_EN
    logic [63:0] mx = (64'd1 << CW) - 64'd1;
    return (64'(c) > mx) ? mx : 64'(c);
`else
    return 64'(c - c);
`endif
  endfunction

  task automatic model_reset();
    hist = '{ent_t'('0), ent_t'('0), ent_t'('0)};
    exp_stall = 0; exp_flush = 0; exp_retire = 0;
  endtask

  task automatic check_all(input string tag);
    ent_t o, x;
    o = '0;
    o.valid = bus.EXvalid; o.wreg = bus.EXwreg; o.m2reg = bus.EXm2reg; o.wmem = bus.EXwmem;
    o.sst = bus.EXsst; o.sext = bus.EXsext; o.shift = bus.EXshift; o.aluc = bus.EXaluc;
    o.sela = bus.EXselectAlua; o.selb = bus.EXselectAlub; o.wn = bus.EXwn; o.stfwd = bus.EXstfwd;
    check({tag, "/ex"}, 64'(o), 64'(hist[0]));
    o = '0; x = '0;
    o.valid = bus.MEMvalid; o.wreg = bus.MEMwreg; o.m2reg = bus.MEMm2reg;
    o.wmem = bus.MEMwmem; o.wn = bus.MEMwn; o.stfwd = bus.MEMstfwd;
    x.valid = hist[1].valid; x.wreg = hist[1].wreg; x.m2reg = hist[1].m2reg;
    x.wmem = hist[1].wmem; x.wn = hist[1].wn; x.stfwd = hist[1].stfwd;
    check({tag, "/mem"}, 64'(o), 64'(x));
    o = '0; x = '0;
    o.valid = bus.WBvalid; o.wreg = bus.WBwreg; o.m2reg = bus.WBm2reg; o.wn = bus.WBwn;
    x.valid = hist[2].valid; x.wreg = hist[2].wreg; x.m2reg = hist[2].m2reg; x.wn = hist[2].wn;
    check({tag, "/wb"}, 64'(o), 64'(x));
    check({tag, "/stall_cnt"},  64'(bus.stall_cnt),  sat(exp_stall));
    check({tag, "/flush_cnt"},  64'(bus.flush_cnt),  sat(exp_flush));
    check({tag, "/retire_cnt"}, 64'(bus.retire_cnt), sat(exp_retire));
  endtask

  // Called at a negedge; advances one clock and checks at the next negedge.
  task automatic step(input string tag);
    ent_t e = id_entry();
    logic in_reset = !rst_n;
    if (!in_reset) begin
      if (!bus.IDwir && !bus.flush) exp_stall++;
      if (bus.flush) exp_flush++;
      if (hist[2].valid) exp_retire++;
    end
    @(posedge clk);
    if (in_reset) model_reset();
    else begin
      hist.push_front(e);
      void'(hist.pop_back());
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    ent_t bub, r;
    logic [31:0] rv;
    n_checks = 0; n_errors = 0;
    bub = '0;
    model_reset();

    // Reset held while ID presents a valid write to r5
    set_id(1'b1, 1'b0, op(1'b1, 1'b0, 1'b0, 4'd0, 5'd5));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    step("rst_release");
    check("rst_release/EXwreg", 64'(bus.EXwreg), 64'd1);
    check("rst_release/EXwn",   64'(bus.EXwn),   64'd5);

    // Pass-through add r7, followed by stall bubbles
    set_id(1'b1, 1'b0, op(1'b1, 1'b0, 1'b0, 4'b0010, 5'd7));
    step("add_ex");
    check("add/EXaluc", 64'(bus.EXaluc), 64'h2);
    set_id(1'b0, 1'b0, bub);
    step("add_mem");
    check("add/MEMwn", 64'(bus.MEMwn), 64'd7);
    step("add_wb");
    check("add/WBwreg", 64'(bus.WBwreg), 64'd1);
    check("add/WBwn",   64'(bus.WBwn),   64'd7);
    step("add_gone");
    check("add/WBvalid_once", 64'(bus.WBvalid), 64'd0);

    // Load-use: lw r3, dependent op held one cycle
    set_id(1'b1, 1'b0, op(1'b1, 1'b1, 1'b0, 4'd0, 5'd3));
    step("lw_ex");
    set_id(1'b0, 1'b0, op(1'b1, 1'b0, 1'b0, 4'd1, 5'd4));
    step("lu_bubble");
    check("lu/EXvalid",   64'(bus.EXvalid),  64'd0);
    check("lu/MEMm2reg",  64'(bus.MEMm2reg), 64'd1);
    check("lu/MEMwn",     64'(bus.MEMwn),    64'd3);
    set_id(1'b1, 1'b0, op(1'b1, 1'b0, 1'b0, 4'd1, 5'd4));
    step("lu_op");
    check("lu/EXwn", 64'(bus.EXwn), 64'd4);

    // Flush alone, then flush together with stall
    set_id(1'b1, 1'b1, op(1'b1, 1'b0, 1'b1, 4'd3, 5'd9));
    step("flush");
    check("flush/EXvalid", 64'(bus.EXvalid), 64'd0);
    set_id(1'b0, 1'b1, op(1'b1, 1'b0, 1'b1, 4'd3, 5'd9));
    step("flush_stall");
    check("flush_stall/EXwmem", 64'(bus.EXwmem), 64'd0);

    // Write to r0 is dropped
    set_id(1'b1, 1'b0, op(1'b1, 1'b0, 1'b0, 4'd5, 5'd0));
    step("r0_ex");
    check("r0/EXwreg",  64'(bus.EXwreg),  64'd0);
    check("r0/EXvalid", 64'(bus.EXvalid), 64'd1);
    set_id(1'b0, 1'b0, bub);
    step("r0_mem");
    step("r0_wb");
    check("r0/WBwreg",  64'(bus.WBwreg),  64'd0);
    check("r0/WBvalid", 64'(bus.WBvalid), 64'd1);

    // Async reset with three ops in flight
    for (int i = 1; i <= 3; i++) begin
      set_id(1'b1, 1'b0, op(1'b1, 1'b0, 1'b0, 4'd2, 5'(i)));
      step("inflight");
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst_now");
    set_id(1'b1, 1'b0, op(1'b1, 1'b0, 1'b0, 4'd2, 5'd6));
    @(negedge clk);
    step("async_rst_hold");
    check("async_rst/WBwreg", 64'(bus.WBwreg), 64'd0);
    rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rv = $urandom;
      r  = ent_t'(rv[$bits(ent_t)-1:0]);
      if ($urandom_range(0, 7) == 0) r.wn = '0;
      set_id(($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0), r);
      step("random");
    end
`ifdef PIPE_PERF_EN
    check("sat/retire_cnt", 64'(bus.retire_cnt), (64'd1 << CW) - 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
